sipo_rx: RTL and testbench
==========================

SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 Parameter WIDTH, default 4, sets the parallel word width; legal range is WIDTH >= 2.
REQ-002 Parameter MSB_FIRST, default 1: 1 = first data bit lands in q[WIDTH-1]; 0 = first data bit lands in q[0].
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-low.
REQ-005 Port d  input  1  serial data line.
REQ-006 Port bit_en  input  1  qualifies d as one serial bit on this clk edge.
REQ-007 Port q  output  WIDTH  received parallel word.
REQ-008 Port q_valid  output  1  q holds an unconsumed word.
REQ-009 Port q_ready  input  1  consumer accepts q when q_valid && q_ready.
REQ-010 Port busy  output  1  a frame is being shifted in.
REQ-011 Port overrun  output  1  sticky flag; a completed word was dropped.

Function
REQ-012 Frame format SHALL be one start bit (d=1) followed by WIDTH data bits, each bit qualified by one bit_en edge.
REQ-013 The FSM SHALL have two states: IDLE and SHIFT.
REQ-014 In IDLE, bit_en && d==1 SHALL move to SHIFT and clear the bit counter; bit_en && d==0 SHALL stay in IDLE (idle line).
REQ-015 In SHIFT, each bit_en edge SHALL sample d into the shift register and increment the counter; with bit_en low, all state SHALL hold.
REQ-016 The bit counter SHALL be $clog2(WIDTH+1) bits wide, counting 0..WIDTH with no wrap.
REQ-017 On the edge sampling the WIDTH-th data bit, the FSM SHALL return to IDLE and the assembled word SHALL complete; no stop bit is used.
REQ-018 A completed word with q_valid low SHALL load q and set q_valid on that same edge; q_valid is therefore visible in the cycle after the last data bit's bit_en edge, WIDTH+1 bit_en edges after the start bit.
REQ-019 q and q_valid SHALL hold while q_valid && !q_ready; q SHALL never change while q_valid is high except under REQ-021.
REQ-020 On a q_valid && q_ready edge with no word completing, q_valid SHALL clear; q retains its last value.
REQ-021 On an edge where a word completes and q_valid && q_ready both hold, the new word SHALL load, q_valid SHALL stay 1, and overrun SHALL be unchanged.
REQ-022 On an edge where a word completes, q_valid is high and q_ready is low, the new word SHALL be dropped, q SHALL keep the old word, and overrun SHALL set.
REQ-023 overrun SHALL stay set until reset.
REQ-024 busy SHALL be 1 exactly when the state is SHIFT.
REQ-025 A start bit arriving while q_valid is high SHALL still be accepted; back-to-back frames need no idle bit.

Reset
REQ-026 While rst is low, asynchronously: state=IDLE, counter=0, shift register=0, q=0, q_valid=0, busy=0, overrun=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial word; the first bit_en && d==1 after release SHALL be treated as a start bit.

Structure
REQ-028 Package sipo_rx_pkg SHALL hold the state typedef (IDLE, SHIFT) and the default WIDTH constant.
REQ-029 One sub-module, sipo_shreg, SHALL implement the WIDTH-bit shift register with a shift-enable input and direction set by MSB_FIRST.
REQ-030 The FSM, counter, output register and handshake SHALL reside in sipo_rx.

Verification
REQ-031 WIDTH=4, MSB_FIRST=1, bit_en every cycle, d=1,1,0,1,1 -> q=4'b1011 and q_valid=1 in the cycle after the 5th edge; busy=1 for 4 cycles.
REQ-032 Same stream with MSB_FIRST=0 -> q=4'b1101.
REQ-033 Same stream with bit_en low for 3 cycles between each bit -> q=4'b1011; state holds through the gaps.
REQ-034 q_ready=0; send 1011 then 0110 -> q=4'b1011, overrun=1. Repeat with q_ready=1 on the second completion edge -> q=4'b0110, q_valid=1, overrun=0.
REQ-035 Pull rst low after 2 data bits, release, then send 1,0,1,1,1 -> q=4'b0111 and no stale bits.
REQ-036 bit_en with d=0 for 10 cycles in IDLE -> busy=0, q_valid=0.

Source files
------------

// File: rtl/sipo_rx_pkg.sv
// Shared types and defaults for the serial-in parallel-out receiver.
package sipo_rx_pkg;

  localparam int unsigned SIPO_WIDTH_DEFAULT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/sipo_rx_if.sv
// Serial input, parallel output handshake and status bundle for sipo_rx.
interface sipo_rx_if
  import sipo_rx_pkg::*;
#(
  parameter int unsigned WIDTH = SIPO_WIDTH_DEFAULT
);

  logic             d;
  logic             bit_en;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             q_ready;
  logic             busy;
  logic             overrun;

  modport master (
    output d, bit_en, q_ready,
    input  q, q_valid, busy, overrun
  );

  modport slave (
    input  d, bit_en, q_ready,
    output q, q_valid, busy, overrun
  );

endinterface

// File: rtl/sipo_rx_shreg.sv
// WIDTH-bit shift register; next_o exposes the post-shift word so the caller
// can capture a completed word on the same edge as its last bit.
module sipo_shreg #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en_i,
  input  logic             d_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] next_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (MSB_FIRST) begin
      data_d = {data_q[WIDTH-2:0], d_i};
    end else begin
      data_d = {d_i, data_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else if (shift_en_i) begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;
  assign next_o = data_d;

endmodule

// File: rtl/sipo_rx.sv
// Start-bit framed serial receiver: IDLE waits for d=1 on bit_en, SHIFT
// collects WIDTH bits, completed words go out on a valid/ready register.
//
//   state | meaning
//   IDLE  | line idle, waiting for a start bit (bit_en && d)
//   SHIFT | shifting data bits in, one per bit_en edge
module sipo_rx
  import sipo_rx_pkg::*;
#(
  parameter int unsigned WIDTH     = SIPO_WIDTH_DEFAULT,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  sipo_rx_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] q_q;
  logic             q_valid_q;
  logic             overrun_q;

  logic [WIDTH-1:0] word_d;
  logic [WIDTH-1:0] shreg_data;
  logic             shift_en;
  logic             last_bit;
  logic             word_done;

  assign shift_en  = (state_q == SHIFT) && bus.bit_en;
  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
  assign word_done = shift_en && last_bit;

  sipo_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (shift_en),
    .d_i        (bus.d),
    .data_o     (shreg_data),
    .next_o     (word_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.bit_en && bus.d) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          if (bus.bit_en) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_bit) begin
              state_q <= IDLE;
            end
          end
        end
      endcase

      // A word finishing against a full, unread output is dropped and flagged.
      if (word_done) begin
        if (!q_valid_q || bus.q_ready) begin
          q_q       <= word_d;
          q_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (q_valid_q && bus.q_ready) begin
        q_valid_q <= 1'b0;
      end
    end
  end

  logic unused_shreg;
  assign unused_shreg = ^shreg_data;

  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;
  assign bus.busy    = (state_q == SHIFT);
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench driving an MSB-first and an LSB-first receiver in lockstep.
module tb_sipo_rx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sipo_rx_if #(.WIDTH(4)) ifm ();
  sipo_rx_if #(.WIDTH(4)) ifl ();

  sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(ifm.slave));
  sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(ifl.slave));

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_m[$];
  logic [3:0] exp_l[$];
  logic [3:0] last_m, last_l;
  logic       rdy_base;

  function automatic logic [3:0] rev4(input logic [3:0] w);
    return {w[0], w[1], w[2], w[3]};
  endfunction

  task automatic drive(input logic be, input logic dv, input logic rdy);
    ifm.bit_en = be;  ifl.bit_en = be;
    ifm.d = dv;       ifl.d = dv;
    ifm.q_ready = rdy; ifl.q_ready = rdy;
  endtask

  task automatic apply_reset();
    drive(1'b0, 1'b0, 1'b0);
    rdy_base = 1'b0;
    rst = 1'b0;
    exp_m.delete();
    exp_l.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Start bit then w[3] down to w[0]; gap idle cycles between bits.
  task automatic send_frame(input logic [3:0] w, input int gap, input bit rdy_last, input bit push);
    logic [4:0] bits;
    bits = {1'b1, w};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, bits[4-i], (rdy_last && i == 4) ? 1'b1 : rdy_base);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, rdy_base);
      checks++;
      if (ifm.busy !== (i < 4))
        begin errors++; $display("FAIL busy_edge%0d: got %b want %b", i, ifm.busy, (i < 4)); end
      if (i < 4) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk);
          #1;
          checks++;
          if (ifm.busy !== 1'b1)
            begin errors++; $display("FAIL busy_gap%0d: got %b want 1", i, ifm.busy); end
        end
      end
    end
    if (push) begin
      exp_m.push_back(w);
      exp_l.push_back(rev4(w));
    end
  endtask

  task automatic expect_word(input string name);
    int n = 0;
    while (!ifm.q_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (ifm.q_valid !== 1'b1 || ifl.q_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid: got m=%b l=%b want 1", name, ifm.q_valid, ifl.q_valid);
    end else if (exp_m.size() == 0) begin
      errors++;
      $display("FAIL %s_sb: output word %b with no expected entry", name, ifm.q);
    end else begin
      last_m = exp_m.pop_front();
      last_l = exp_l.pop_front();
      if (ifm.q !== last_m) begin errors++; $display("FAIL %s_q_msb: got %b want %b", name, ifm.q, last_m); end
      checks++;
      if (ifl.q !== last_l) begin errors++; $display("FAIL %s_q_lsb: got %b want %b", name, ifl.q, last_l); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    #3;
    checks++;
    if ({ifm.q, ifm.q_valid, ifm.busy, ifm.overrun} !== 7'b0)
      begin errors++; $display("FAIL reset_msb: got q=%b v=%b b=%b o=%b want all 0", ifm.q, ifm.q_valid, ifm.busy, ifm.overrun); end
    checks++;
    if ({ifl.q, ifl.q_valid, ifl.busy, ifl.overrun} !== 7'b0)
      begin errors++; $display("FAIL reset_lsb: got q=%b v=%b b=%b o=%b want all 0", ifl.q, ifl.q_valid, ifl.busy, ifl.overrun); end
    apply_reset();
  endtask

  task automatic test_idle();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checks++;
      if (ifm.busy !== 1'b0 || ifm.q_valid !== 1'b0)
        begin errors++; $display("FAIL idle%0d: got busy=%b valid=%b want 0 0", i, ifm.busy, ifm.q_valid); end
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    apply_reset();
    send_frame(4'b1011, 0, 1'b0, 1'b1);
    expect_word("basic");
    drive(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (ifm.q_valid !== 1'b0 || ifm.q !== last_m)
      begin errors++; $display("FAIL consume: got valid=%b q=%b want 0 %b", ifm.q_valid, ifm.q, last_m); end
  endtask

  task automatic test_gaps();
    apply_reset();
    send_frame(4'b1011, 3, 1'b0, 1'b1);
    expect_word("gaps");
  endtask

  task automatic test_overrun();
    apply_reset();
    send_frame(4'b1011, 0, 1'b0, 1'b1);
    send_frame(4'b0110, 0, 1'b0, 1'b0);
    expect_word("ovr_drop");
    checks++;
    if (ifm.overrun !== 1'b1 || ifl.overrun !== 1'b1)
      begin errors++; $display("FAIL ovr_flag: got m=%b l=%b want 1", ifm.overrun, ifl.overrun); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ifm.overrun !== 1'b1)
      begin errors++; $display("FAIL ovr_sticky: got %b want 1", ifm.overrun); end

    apply_reset();
    send_frame(4'b1011, 0, 1'b0, 1'b1);
    expect_word("ovr_first");
    send_frame(4'b0110, 0, 1'b1, 1'b1);
    expect_word("ovr_replace");
    checks++;
    if (ifm.overrun !== 1'b0 || ifl.overrun !== 1'b0)
      begin errors++; $display("FAIL ovr_clear: got m=%b l=%b want 0", ifm.overrun, ifl.overrun); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] words [3];
    words = '{4'b1001, 4'b0101, 4'b1110};
    apply_reset();
    rdy_base = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_frame(words[k], 0, 1'b0, 1'b1);
      expect_word("b2b");
    end
    rdy_base = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (ifm.overrun !== 1'b0)
      begin errors++; $display("FAIL b2b_overrun: got %b want 0", ifm.overrun); end
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    drive(1'b1, 1'b1, 1'b0); @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0); @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0); @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (ifm.busy !== 1'b1)
      begin errors++; $display("FAIL mid_busy: got %b want 1", ifm.busy); end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (ifm.busy !== 1'b0 || ifm.q_valid !== 1'b0)
      begin errors++; $display("FAIL mid_async: got busy=%b valid=%b want 0 0", ifm.busy, ifm.q_valid); end
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    send_frame(4'b0111, 0, 1'b0, 1'b1);
    expect_word("mid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rdy_base = 1'b0;
    test_reset();
    test_idle();
    test_basic();
    test_gaps();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
